// File: rtl/mano_mem_arbiter_if.sv
// Bus bundle between the two memory masters (CPU, DMA), the arbiter and the
// single MANO main memory. The arbiter uses the slave view; the environment
// (masters plus memory) uses the master view.
interface mano_mem_arbiter_if #(
    parameter int unsigned AW = 12,
    parameter int unsigned DW = 16
);
    // CPU port
    logic          c_req;
    logic          c_wr;
    logic [AW-1:0] c_addr;
    logic [DW-1:0] c_din;
    logic          c_ack;
    logic [DW-1:0] c_dout;
    // DMA / loader port
    logic          d_req;
    logic          d_wr;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_din;
    logic          d_lock;
    logic          d_ack;
    logic [DW-1:0] d_dout;
    // Memory side
    logic [AW-1:0] m_addr;
    logic          m_rd;
    logic          m_wr;
    logic [DW-1:0] m_din;
    logic [DW-1:0] m_dout;
    // Status
    logic          busy;
    logic          owner;

    modport slave (
        input  c_req, c_wr, c_addr, c_din,
        input  d_req, d_wr, d_addr, d_din, d_lock,
        input  m_dout,
        output c_ack, c_dout, d_ack, d_dout,
        output m_addr, m_rd, m_wr, m_din,
        output busy, owner
    );

    modport master (
        output c_req, c_wr, c_addr, c_din,
        output d_req, d_wr, d_addr, d_din, d_lock,
        output m_dout,
        input  c_ack, c_dout, d_ack, d_dout,
        input  m_addr, m_rd, m_wr, m_din,
        input  busy, owner
    );
endinterface

// File: rtl/mano_mem_arbiter.sv
// Two-port arbiter for the MANO 4096x16 main memory. Every access runs
// IDLE -> ACC -> ACK. Ties are broken round-robin, except that a DMA master
// holding d_lock keeps the memory for up to MAX_BURST consecutive grants
// while the CPU waits.
module mano_mem_arbiter #(
    parameter int unsigned AW        = 12,
    parameter int unsigned DW        = 16,
    parameter int unsigned MAX_BURST = 4
) (
    input  logic                clk,
    input  logic                rst,
    mano_mem_arbiter_if.slave   bus
);

    localparam logic [3:0] BURST_MAX = 4'(MAX_BURST);

    typedef enum logic [1:0] {
        IDLE,
        ACC,
        ACK
    } state_t;

    state_t        state_q, state_d;
    logic          any_req;
    logic          lock_bias;
    logic          grant_dma;

    logic          op_wr_q;
    logic          owner_q;
    logic          last_owner_q;
    logic          lock_held_q;
    logic [3:0]    burst_cnt_q;
    logic [AW-1:0] m_addr_q;
    logic [DW-1:0] m_din_q;
    logic [DW-1:0] c_dout_q;
    logic [DW-1:0] d_dout_q;

    // Next-state and winner selection; winner is only meaningful in IDLE.
    always_comb begin
        state_d   = state_q;
        any_req   = bus.c_req | bus.d_req;
        lock_bias = lock_held_q && (burst_cnt_q < BURST_MAX);
        grant_dma = bus.d_req & (~bus.c_req | lock_bias | ~last_owner_q);
        case (state_q)
            IDLE:    if (any_req) state_d = ACC;
            ACC:     state_d = ACK;
            ACK:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Latch the winning request into the operation/memory-side registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            owner_q  <= 1'b0;
            op_wr_q  <= 1'b0;
            m_addr_q <= '0;
            m_din_q  <= '0;
        end else if (state_q == IDLE && any_req) begin
            owner_q  <= grant_dma;
            op_wr_q  <= grant_dma ? bus.d_wr   : bus.c_wr;
            m_addr_q <= grant_dma ? bus.d_addr : bus.c_addr;
            m_din_q  <= grant_dma ? bus.d_din  : bus.c_din;
        end
    end

    // Capture read data into the owning master's result register only.
    always_ff @(posedge clk) begin
        if (rst) begin
            c_dout_q <= '0;
            d_dout_q <= '0;
        end else if (state_q == ACC && !op_wr_q) begin
            if (owner_q) d_dout_q <= bus.m_dout;
            else         c_dout_q <= bus.m_dout;
        end
    end

    // Fairness bookkeeping, updated once per completed access.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_owner_q <= 1'b1;
            lock_held_q  <= 1'b0;
            burst_cnt_q  <= '0;
        end else if (state_q == ACK) begin
            last_owner_q <= owner_q;
            if (owner_q) begin
                lock_held_q <= bus.d_lock;
                if (!bus.d_lock)                 burst_cnt_q <= '0;
                else if (burst_cnt_q != BURST_MAX) burst_cnt_q <= burst_cnt_q + 4'd1;
            end else begin
                lock_held_q <= 1'b0;
                burst_cnt_q <= '0;
            end
        end
    end

    // A reset landing in the ACC cycle must not commit the write.
    assign bus.m_wr   = (state_q == ACC) & op_wr_q & ~rst;
    assign bus.m_rd   = (state_q == ACC) & ~op_wr_q;
    assign bus.m_addr = m_addr_q;
    assign bus.m_din  = m_din_q;
    assign bus.c_ack  = (state_q == ACK) & ~owner_q;
    assign bus.d_ack  = (state_q == ACK) & owner_q;
    assign bus.c_dout = c_dout_q;
    assign bus.d_dout = d_dout_q;
    assign bus.busy   = (state_q != IDLE);
    assign bus.owner  = owner_q;

endmodule
